cbfp_block_norm: RTL and testbench

CBFP_BLOCK_NORM -- requirements
Module: cbfp_block_norm

---
 rtl/cbfp_pkg.sv | 27 ++
 rtl/cbfp_lsc.sv | 14 +
 rtl/cbfp_block_norm.sv | 137 +++++++++++++
 tb/tb_cbfp_block_norm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// Shared definitions for the block-floating-point normaliser: index mode
// and the redundant-sign-bit count.
package cbfp_pkg;

    typedef enum logic {
        CBFP_SHARED   = 1'b0,
        CBFP_PER_LANE = 1'b1
    } cbfp_mode_e;

    localparam int CBFP_MAX_W = 64;

    // x must be sign-extended to CBFP_MAX_W; w is the meaningful width.
    function automatic int sign_bits(input logic [CBFP_MAX_W-1:0] x, input int w);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = CBFP_MAX_W - 2; i >= 0; i--) begin
            if (i <= w - 2 && run) begin
                if (x[i] == x[CBFP_MAX_W-1]) n++;
                else                         run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/cbfp_lsc.sv
// Leading-sign counter: number of redundant sign bits of one component.
module cbfp_lsc
    import cbfp_pkg::*;
#(
    parameter int W     = 25,
    parameter int IDX_W = 5
) (
    input  logic [W-1:0]     x,
    output logic [IDX_W-1:0] s
);

    assign s = IDX_W'(sign_bits({{(CBFP_MAX_W - W){x[W-1]}}, x}, W));

endmodule

// File: rtl/cbfp_block_norm.sv
// Convergent block-floating-point normaliser: finds the common exponent of a
// BLK-beat block, buffers it in a ping-pong RAM and drains it shifted/rounded.
module cbfp_block_norm
    import cbfp_pkg::*;
#(
    parameter  int N        = 16,
    parameter  int IN_W     = 25,
    parameter  int OUT_W    = 12,
    parameter  int BLK      = 4,
    parameter  int MODE     = 0,
    parameter  int ROUND_EN = 1,
    localparam int IDX_W    = $clog2(IN_W)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic [N-1:0][IN_W-1:0]      din_re,
    input  logic [N-1:0][IN_W-1:0]      din_im,
    output logic                        valid_out,
    output logic [N-1:0][OUT_W-1:0]     dout_re,
    output logic [N-1:0][OUT_W-1:0]     dout_im,
    output logic [N-1:0][IDX_W-1:0]     index_out
);

    localparam int CW = $clog2(BLK);
    localparam int D  = IN_W - OUT_W;

    typedef enum logic {IDLE, DRAIN} state_e;

    state_e                        state;
    logic [CW-1:0]                 fill_cnt, rd_cnt;
    logic                          wr_bank, rd_bank, pend, blk_done, take;
    logic [N-1:0][IDX_W-1:0]       s_re, s_im, lane_s, beat_s, cur_s, min_q;
    logic [1:0][N-1:0][IDX_W-1:0]  shift_q;
    logic [IDX_W-1:0]              blk_min;
    logic [N-1:0][OUT_W-1:0]       norm_re, norm_im;
    logic [N-1:0][IN_W-1:0]        mem_re [2][BLK];
    logic [N-1:0][IN_W-1:0]        mem_im [2][BLK];

    // Shift never exceeds the sign headroom, so the left shift cannot overflow.
    function automatic logic [OUT_W-1:0] norm(input logic [IN_W-1:0] x,
                                              input logic [IDX_W-1:0] sh);
        logic        [IN_W-1:0] y;
        logic signed [OUT_W:0]  r;
        y = x << sh;
        r = $signed({y[IN_W-1], y[IN_W-1:D]});
        if (ROUND_EN != 0) r = r + $signed({{OUT_W{1'b0}}, y[D-1]});
        if (r > $signed({2'b00, {(OUT_W-1){1'b1}}})) r = $signed({2'b00, {(OUT_W-1){1'b1}}});
        return r[OUT_W-1:0];
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_lane
        cbfp_lsc #(.W(IN_W), .IDX_W(IDX_W)) u_lsc_re (.x(din_re[i]), .s(s_re[i]));
        cbfp_lsc #(.W(IN_W), .IDX_W(IDX_W)) u_lsc_im (.x(din_im[i]), .s(s_im[i]));
        assign lane_s[i]  = (s_re[i] < s_im[i]) ? s_re[i] : s_im[i];
        assign norm_re[i] = norm(mem_re[rd_bank][rd_cnt][i], shift_q[rd_bank][i]);
        assign norm_im[i] = norm(mem_im[rd_bank][rd_cnt][i], shift_q[rd_bank][i]);
    end

    // Running minimum restarts from the current beat at the top of each block.
    always_comb begin
        blk_min = lane_s[0];
        for (int i = 1; i < N; i++)
            if (lane_s[i] < blk_min) blk_min = lane_s[i];
        beat_s = '0;
        cur_s  = '0;
        for (int i = 0; i < N; i++) begin
            beat_s[i] = (MODE == int'(CBFP_PER_LANE)) ? lane_s[i] : blk_min;
            cur_s[i]  = (fill_cnt == '0 || beat_s[i] < min_q[i]) ? beat_s[i] : min_q[i];
        end
    end

    assign blk_done = valid_in && (fill_cnt == CW'(BLK - 1));
    assign take     = pend && (state == IDLE || rd_cnt == CW'(BLK - 1));

    always_ff @(posedge clk) begin
        if (valid_in) begin
            mem_re[wr_bank][fill_cnt] <= din_re;
            mem_im[wr_bank][fill_cnt] <= din_im;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= '0;
            wr_bank  <= 1'b0;
            pend     <= 1'b0;
            min_q    <= '0;
            shift_q  <= '0;
        end else begin
            if (valid_in) begin
                min_q    <= cur_s;
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (blk_done) begin
                shift_q[wr_bank] <= cur_s;
                wr_bank          <= ~wr_bank;
            end
            if (blk_done)  pend <= 1'b1;
            else if (take) pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            valid_out <= 1'b0;
            dout_re   <= '0;
            dout_im   <= '0;
            index_out <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: if (pend) begin
                    state   <= DRAIN;
                    rd_cnt  <= '0;
                    rd_bank <= ~wr_bank;
                end
                DRAIN: begin
                    valid_out <= 1'b1;
                    dout_re   <= norm_re;
                    dout_im   <= norm_im;
                    if (rd_cnt == '0) index_out <= shift_q[rd_bank];
                    rd_cnt <= rd_cnt + 1'b1;
                    // Back-to-back blocks chain straight into the other bank.
                    if (rd_cnt == CW'(BLK - 1)) begin
                        if (pend) rd_bank <= ~rd_bank;
                        else      state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbfp_block_norm.sv
// Scoreboard bench for cbfp_block_norm: directed blocks with hand-computed
// exponents and outputs, checked with exact output timing.
module tb_cbfp_block_norm;

    localparam int N     = 16;
    localparam int IN_W  = 25;
    localparam int OUT_W = 12;
    localparam int IDX_W = 5;

    typedef logic [N-1:0][IN_W-1:0]  in_vec_t;
    typedef logic [N-1:0][OUT_W-1:0] out_vec_t;
    typedef logic [N-1:0][IDX_W-1:0] idx_vec_t;
    typedef struct {
        out_vec_t re;
        out_vec_t im;
        idx_vec_t idx;
        int       cyc;
    } exp_t;

    logic     clk = 1'b0, rst = 1'b1, valid_in = 1'b0, valid_in1 = 1'b0;
    in_vec_t  din_re = '0, din_im = '0;
    logic     valid_out, valid_out1;
    out_vec_t dout_re, dout_im, dout_re1, dout_im1;
    idx_vec_t index_out, index_out1;

    int   checks = 0, errors = 0, cyc = 0, tot_exp = 0, tot_got = 0;
    exp_t q0[$], q1[$];

    cbfp_block_norm #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .BLK(4), .MODE(0), .ROUND_EN(1)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din_re(din_re), .din_im(din_im),
        .valid_out(valid_out), .dout_re(dout_re), .dout_im(dout_im), .index_out(index_out));

    cbfp_block_norm #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .BLK(4), .MODE(1), .ROUND_EN(1)) dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in1), .din_re(din_re), .din_im(din_im),
        .valid_out(valid_out1), .dout_re(dout_re1), .dout_im(dout_im1), .index_out(index_out1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic in_vec_t rep_in(input int v);
        for (int i = 0; i < N; i++) rep_in[i] = IN_W'(v);
    endfunction
    function automatic out_vec_t rep_out(input int v);
        for (int i = 0; i < N; i++) rep_out[i] = OUT_W'(v);
    endfunction
    function automatic idx_vec_t rep_idx(input int v);
        for (int i = 0; i < N; i++) rep_idx[i] = IDX_W'(v);
    endfunction

    // Monitors: pop one expectation per output beat.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid_out) begin
            tot_got++;
            if (q0.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                e = q0.pop_front();
                chk("dout_re", dout_re, e.re);
                chk("dout_im", dout_im, e.im);
                chk("index_out", index_out, e.idx);
                chk("out_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid_out1) begin
            if (q1.size() == 0) chk("unexpected_out1", 1, 0);
            else begin
                e = q1.pop_front();
                chk("m1_dout_re", dout_re1, e.re);
                chk("m1_dout_im", dout_im1, e.im);
                chk("m1_index_out", index_out1, e.idx);
                chk("m1_out_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic push0(input out_vec_t re, input out_vec_t im, input idx_vec_t idx, input int c);
        exp_t e;
        e.re = re; e.im = im; e.idx = idx; e.cyc = c;
        q0.push_back(e);
        tot_exp++;
    endtask

    // Beat is sampled on the next rising edge, numbered cyc+1.
    task automatic drive_beat(input in_vec_t re, input in_vec_t im, input logic v1, output int t);
        @(negedge clk);
        din_re = re; din_im = im; valid_in = 1'b1; valid_in1 = v1;
        t = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0; valid_in1 = 1'b0;
        end
    endtask

    task automatic send_block(input int v[4], input bit neg, input int gap,
                              input int e[4], input int ei);
        int t;
        for (int j = 0; j < 4; j++) begin
            drive_beat(rep_in(v[j]), rep_in(neg ? -v[j] : v[j]), 1'b0, t);
            if (j < 3) idle(gap);
        end
        for (int j = 0; j < 4; j++)
            push0(rep_out(e[j]), rep_out(neg ? -e[j] : e[j]), rep_idx(ei), t + 2 + j);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
    endtask

    initial begin
        int va[4], ea[4], t;
        in_vec_t  r;
        out_vec_t er0, er1, ei1;
        idx_vec_t ix1;
        exp_t     e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_dout_re", dout_re, 0);
        chk("rst_dout_im", dout_im, 0);
        chk("rst_index_out", index_out, 0);
        rst = 1'b0;

        // All components 1000: exponent 14, output 2000.
        va = '{1000, 1000, 1000, 1000}; ea = '{2000, 2000, 2000, 2000};
        send_block(va, 1'b0, 0, ea, 14);
        idle(1); wait_drain();

        // One lane at full scale: shared exponent collapses to 0; per-lane keeps 14.
        r = rep_in(1000); r[1] = IN_W'(-(1 << 24));
        for (int j = 0; j < 4; j++) drive_beat(r, rep_in(1000), 1'b1, t);
        er0 = rep_out(0); er0[1] = OUT_W'(-2048);
        er1 = rep_out(2000); er1[1] = OUT_W'(-2048);
        ei1 = rep_out(2000); ei1[1] = '0;
        ix1 = rep_idx(14); ix1[1] = '0;
        for (int j = 0; j < 4; j++) begin
            push0(er0, rep_out(0), rep_idx(0), t + 2 + j);
            e.re = er1; e.im = ei1; e.idx = ix1; e.cyc = t + 2 + j;
            q1.push_back(e);
        end
        idle(1); wait_drain();

        // All-zero block, then a full-headroom block that rounds into saturation.
        va = '{0, 0, 0, 0}; ea = '{0, 0, 0, 0};
        send_block(va, 1'b0, 0, ea, 24);
        va = '{8388607, 8388607, 8388607, 8388607}; ea = '{2047, 2047, 2047, 2047};
        send_block(va, 1'b0, 0, ea, 1);
        idle(1); wait_drain();

        // Gapped beats still form one block with contiguous output.
        va = '{1000, 2000, 3000, 4000}; ea = '{500, 1000, 1500, 2000};
        send_block(va, 1'b1, 3, ea, 12);
        idle(1); wait_drain();

        // Three blocks with continuous valid_in.
        va = '{1000, -1000, 500, -500}; ea = '{2000, -2000, 1000, -1000};
        send_block(va, 1'b1, 0, ea, 14);
        va = '{3, -3, 2, 1}; ea = '{1536, -1536, 1024, 512};
        send_block(va, 1'b1, 0, ea, 22);
        va = '{1000, 1000, 1000, 1000}; ea = '{2000, 2000, 2000, 2000};
        send_block(va, 1'b0, 0, ea, 14);
        idle(1); wait_drain();

        // Partial block discarded by reset.
        drive_beat(rep_in(5000), rep_in(5000), 1'b0, t);
        drive_beat(rep_in(6000), rep_in(6000), 1'b0, t);
        @(negedge clk); valid_in = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        va = '{1000, -1000, 500, -500}; ea = '{2000, -2000, 1000, -1000};
        send_block(va, 1'b1, 0, ea, 14);
        idle(1); wait_drain();

        // Reset mid-drain: outputs clear asynchronously and the drain is abandoned.
        va = '{1000, 1000, 1000, 1000}; ea = '{2000, 2000, 2000, 2000};
        send_block(va, 1'b0, 0, ea, 14);
        idle(1);
        for (int i = 0; i < 20 && !valid_out; i++) @(negedge clk);
        chk("mid_drain_started", valid_out, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid_out", valid_out, 0);
        chk("async_rst_dout_re", dout_re, 0);
        chk("async_rst_dout_im", dout_im, 0);
        chk("async_rst_index_out", index_out, 0);
        tot_exp -= q0.size();
        q0.delete();
        @(negedge clk); rst = 1'b0;
        idle(12);
        chk("beat_total", tot_got, tot_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
